// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   CH-input, N-bit stream multiplexer with valid/ready handshakes on every
//   channel and a single registered output stage. The channel is chosen either
//   by a fixed select (MODE=0) or by round-robin arbitration (MODE=1).
//
// Parameters
//   N     data width per channel (bits)
//   CH    number of input channels (>= 2)
//   MODE  0 = fixed select via sel, 1 = round-robin (sel ignored)
//   SW    derived select/index width, $clog2(CH)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_data    in   CH*N   channel k at bits [k*N +: N]
//   in_valid   in   CH     per-channel valid
//   in_ready   out  CH     per-channel ready (combinational, one-hot or zero)
//   sel        in   SW     channel select, used only when MODE=0
//   out_data   out  N      registered output data
//   out_valid  out  1      registered output valid
//   out_ready  in   1      consumer ready
//   out_ch     out  SW     index of the channel that sourced out_data
//   in_last    in   CH     (STREAM_MUX_LAST_LOCK_EN only) end-of-packet flag
//   out_last   out  1      (STREAM_MUX_LAST_LOCK_EN only) registered last flag
//
// Configuration
//   STREAM_MUX_LAST_LOCK_EN  when defined, a beat with in_last=0 locks the
//   grant to its channel until that channel's in_last=1 beat transfers, so a
//   packet is never interleaved with another channel's beats.
// -----------------------------------------------------------------------------
module stream_mux_rr #(
   parameter  int N    = 8,
   parameter  int CH   = 4,
   parameter  int MODE = 1,
   localparam int SW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   input  logic [SW-1:0]     sel,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
   output logic [SW-1:0]     out_ch,
   input  logic [CH-1:0]     in_last,
   output logic              out_last
`else
   output logic [SW-1:0]     out_ch
`endif
);

   localparam int unsigned CHU = CH;

   logic              load;        // output register can accept a beat this cycle
   logic [SW-1:0]     ptr;         // last granted channel (round-robin origin)
   logic              lock;        // grant pinned to lock_ch until end of packet
   logic [SW-1:0]     lock_ch;
   logic              rr_found;
   logic [SW-1:0]     rr_grant;
   logic              grant_ok;    // some channel holds the grant
   logic [SW-1:0]     grant;
   logic              grant_valid;
   logic [N-1:0]      grant_data;
   logic              xfer;        // beat moves from channel 'grant' to the output
   int unsigned       idx;
`ifdef STREAM_MUX_LAST_LOCK_EN
   logic              grant_last;
`endif

   // An empty output register, or one being drained this cycle, can be reloaded.
   assign load = !out_valid | out_ready;

   // Round-robin search: first valid channel strictly after ptr, wrapping.
   // Searching ptr+1 .. ptr+CH means the last-served channel has lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      idx      = 0;
      for (int unsigned i = 1; i <= CHU; i++) begin
         idx = (32'(ptr) + i) % CHU;
         if (!rr_found && in_valid[idx[SW-1:0]]) begin
            rr_found = 1'b1;
            rr_grant = idx[SW-1:0];
         end
      end
   end

   // Grant source: an active packet lock overrides both select modes.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (lock) begin
         grant    = lock_ch;
         grant_ok = 1'b1;
      end else if (MODE == 0) begin
         grant    = sel;
         grant_ok = (32'(sel) < CHU);
      end else begin
         grant    = rr_grant;
         grant_ok = rr_found;
      end
   end

   // Decode the grant into the ready vector and the selected channel's payload.
   always_comb begin
      in_ready    = '0;
      grant_valid = 1'b0;
      grant_data  = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      grant_last  = 1'b0;
`endif
      for (int unsigned k = 0; k < CHU; k++) begin
         if (grant_ok && (grant == SW'(k))) begin
            in_ready[k] = load & !rst;
            grant_valid = in_valid[k];
            grant_data  = in_data[k*N +: N];
`ifdef STREAM_MUX_LAST_LOCK_EN
            grant_last  = in_last[k];
`endif
         end
      end
   end

   assign xfer = load & grant_valid & !rst;

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SW'(CH - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_ch    <= grant;
         ptr       <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef STREAM_MUX_LAST_LOCK_EN
   // Every transfer re-evaluates the lock: a non-last beat pins (or keeps) the
   // grant on its channel, the last beat releases it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock     <= 1'b0;
         lock_ch  <= '0;
         out_last <= 1'b0;
      end else if (xfer) begin
         lock     <= !grant_last;
         lock_ch  <= grant;
         out_last <= grant_last;
      end
   end
`else
   assign lock    = 1'b0;
   assign lock_ch = '0;
`endif

endmodule
